// File: rtl/spi_display_host_pkg.sv
// Shared definitions for the SPI display host: panel command codes, FSM states, argument byte selection.
package spi_display_host_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_RASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    typedef enum logic [3:0] {
        IDLE,
        CS_SETUP,
        C2A,
        A2A,
        C2B,
        A2B,
        C2C,
        PIX_WAIT,
        PIX_HI,
        PIX_LO,
        CS_HOLD
    } state_t;

    // Picks one of the four window argument bytes: start high, start low, end high, end low
    function automatic logic [7:0] arg_byte(input logic [15:0] first_coord,
                                            input logic [15:0] last_coord,
                                            input logic [1:0]  idx);
        logic [7:0] result;
        case (idx)
            2'd0:    result = first_coord[15:8];
            2'd1:    result = first_coord[7:0];
            2'd2:    result = last_coord[15:8];
            default: result = last_coord[7:0];
        endcase
        return result;
    endfunction

endpackage

// File: rtl/spi_display_host_byte_tx.sv
// Byte serialiser for the display host: shifts one byte out MSB first on a mode-0 SPI clock.
module spi_byte_tx #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    input  logic       dc,
    output logic       done,
    output logic       spi_clk,
    output logic       spi_do,
    output logic       spi_dc
);

    logic        active;
    logic [15:0] div_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic        half_end;

    assign half_end = active && (div_cnt == 16'(CLK_DIV - 1));

    // done marks the edge that ends the last high phase, so a chained load lands on that same edge with no gap
    assign done = half_end && spi_clk && (bit_cnt == 3'd7);

    // Half-period timing, clock generation and shifting; a load always starts a fresh low phase
    always_ff @(posedge clk) begin
        if (reset) begin
            active  <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            spi_clk <= 1'b0;
            spi_do  <= 1'b0;
            spi_dc  <= 1'b0;
        end else if (load) begin
            active  <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
            shift   <= data;
            spi_clk <= 1'b0;
            spi_do  <= data[7];
            spi_dc  <= dc;
        end else if (active) begin
            if (half_end) begin
                div_cnt <= '0;
                if (!spi_clk) begin
                    spi_clk <= 1'b1;
                end else begin
                    spi_clk <= 1'b0;
                    if (bit_cnt == 3'd7) begin
                        active <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                        spi_do  <= shift[6];
                        shift   <= {shift[6:0], 1'b0};
                    end
                end
            end else begin
                div_cnt <= div_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/spi_display_host.sv
// Host-side SPI master for an ILI9340-style panel: window commands followed by an RGB565 pixel stream.
module spi_display_host #(
    parameter int WIDTH   = 16,
    parameter int CLK_DIV = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] x_start,
    input  logic [WIDTH-1:0] y_start,
    input  logic [WIDTH-1:0] x_end,
    input  logic [WIDTH-1:0] y_end,
    input  logic             win_valid,
    output logic             win_ready,
    input  logic [15:0]      pixel_data,
    input  logic             pixel_last,
    input  logic             pixel_valid,
    output logic             pixel_ready,
    output logic             busy,
    output logic             spi_clk,
    output logic             spi_cs,
    output logic             spi_do,
    output logic             spi_dc
);

    import spi_display_host_pkg::*;

    state_t      state;
    state_t      state_next;
    logic        ready_ok;
    logic [15:0] x_first;
    logic [15:0] x_last;
    logic [15:0] y_first;
    logic [15:0] y_last;
    logic [7:0]  pix_lo;
    logic        pix_last;
    logic [1:0]  arg_idx;
    logic [15:0] hold_cnt;
    logic        load;
    logic [7:0]  tx_data;
    logic        tx_dc;
    logic        done;

    assign win_ready   = (state == IDLE) && ready_ok;
    assign pixel_ready = (state == PIX_WAIT);
    assign busy        = (state != IDLE);

    spi_byte_tx #(
        .CLK_DIV(CLK_DIV)
    ) u_byte_tx (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .data    (tx_data),
        .dc      (tx_dc),
        .done    (done),
        .spi_clk (spi_clk),
        .spi_do  (spi_do),
        .spi_dc  (spi_dc)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state sequencing; each byte state chains the following byte on the serialiser's done edge
    always_comb begin
        state_next = state;
        load       = 1'b0;
        tx_data    = 8'h00;
        tx_dc      = 1'b0;
        case (state)
            IDLE: begin
                if (win_valid && win_ready) begin
                    state_next = CS_SETUP;
                end
            end
            CS_SETUP: begin
                load       = 1'b1;
                tx_data    = CMD_CASET;
                state_next = C2A;
            end
            C2A: begin
                if (done) begin
                    load       = 1'b1;
                    tx_data    = arg_byte(x_first, x_last, 2'd0);
                    tx_dc      = 1'b1;
                    state_next = A2A;
                end
            end
            A2A: begin
                if (done) begin
                    load = 1'b1;
                    if (arg_idx == 2'd3) begin
                        tx_data    = CMD_RASET;
                        state_next = C2B;
                    end else begin
                        tx_data = arg_byte(x_first, x_last, arg_idx + 2'd1);
                        tx_dc   = 1'b1;
                    end
                end
            end
            C2B: begin
                if (done) begin
                    load       = 1'b1;
                    tx_data    = arg_byte(y_first, y_last, 2'd0);
                    tx_dc      = 1'b1;
                    state_next = A2B;
                end
            end
            A2B: begin
                if (done) begin
                    load = 1'b1;
                    if (arg_idx == 2'd3) begin
                        tx_data    = CMD_RAMWR;
                        state_next = C2C;
                    end else begin
                        tx_data = arg_byte(y_first, y_last, arg_idx + 2'd1);
                        tx_dc   = 1'b1;
                    end
                end
            end
            C2C: begin
                if (done) begin
                    state_next = PIX_WAIT;
                end
            end
            PIX_WAIT: begin
                if (pixel_valid) begin
                    load       = 1'b1;
                    tx_data    = pixel_data[15:8];
                    tx_dc      = 1'b1;
                    state_next = PIX_HI;
                end
            end
            PIX_HI: begin
                if (done) begin
                    load       = 1'b1;
                    tx_data    = pix_lo;
                    tx_dc      = 1'b1;
                    state_next = PIX_LO;
                end
            end
            PIX_LO: begin
                if (done) begin
                    state_next = pix_last ? CS_HOLD : PIX_WAIT;
                end
            end
            CS_HOLD: begin
                if (hold_cnt == 16'(CLK_DIV - 1)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Window and pixel latches, argument index, chip select and the hold timer
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_ok <= 1'b0;
            x_first  <= '0;
            x_last   <= '0;
            y_first  <= '0;
            y_last   <= '0;
            pix_lo   <= '0;
            pix_last <= 1'b0;
            arg_idx  <= '0;
            hold_cnt <= '0;
            spi_cs   <= 1'b1;
        end else begin
            ready_ok <= 1'b1;
            if (state == IDLE && win_valid && win_ready) begin
                x_first <= 16'(x_start);
                x_last  <= 16'(x_end);
                y_first <= 16'(y_start);
                y_last  <= 16'(y_end);
            end
            if (state == PIX_WAIT && pixel_valid) begin
                pix_lo   <= pixel_data[7:0];
                pix_last <= pixel_last;
            end
            if (state == C2A || state == C2B) begin
                arg_idx <= '0;
            end else if ((state == A2A || state == A2B) && done) begin
                arg_idx <= arg_idx + 2'd1;
            end
            if (state == CS_HOLD) begin
                hold_cnt <= hold_cnt + 16'd1;
            end else begin
                hold_cnt <= '0;
            end
            if (state == CS_SETUP) begin
                spi_cs <= 1'b0;
            end else if (state == CS_HOLD && state_next == IDLE) begin
                spi_cs <= 1'b1;
            end
        end
    end

endmodule
